// File: rtl/comparator_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit magnitude comparator between
// NUM_REQ requesters and returns each result, tagged with its owner, on a shared response bus.

module comparator_four_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       greater_than,
  output logic       less_than,
  output logic       equal
);
  logic [3:0] same;

  // MSB-first cascade: a bit decides the result only if every higher bit matched.
  assign same         = ~(a ^ b);
  assign greater_than = (a[3] & ~b[3])
                      | (same[3] & a[2] & ~b[2])
                      | (same[3] & same[2] & a[1] & ~b[1])
                      | (same[3] & same[2] & same[1] & a[0] & ~b[0]);
  assign less_than    = (~a[3] & b[3])
                      | (same[3] & ~a[2] & b[2])
                      | (same[3] & same[2] & ~a[1] & b[1])
                      | (same[3] & same[2] & same[1] & ~a[0] & b[0]);
  assign equal        = &same;
endmodule

module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_gt,
  output logic                 resp_lt,
  output logic                 resp_eq,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count,
  output logic [1:0]           state_dbg
);
  // Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i] is high;
  // a response transfers on a cycle where resp_valid & resp_ready is high. Neither side
  // may make its valid depend on the other's ready, and resp_* hold while resp_valid waits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     cur_id;
  logic [3:0]         op_a;
  logic [3:0]         op_b;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic [3:0]         sel_a;
  logic [3:0]         sel_b;
  logic               handshake;
  int                 idx;

  logic               cmp_gt;
  logic               cmp_lt;
  logic               cmp_eq;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = IDW'(idx);
        sel_a         = req_a[4*idx +: 4];
        sel_b         = req_b[4*idx +: 4];
      end
    end
  end

  assign handshake = (state == IDLE) && grant_any && !rst;
  assign req_ready = handshake ? grant_oh : '0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  comparator_four_bit u_cmp (
    .a            (op_a),
    .b            (op_b),
    .greater_than (cmp_gt),
    .less_than    (cmp_lt),
    .equal        (cmp_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_gt    <= 1'b0;
      resp_lt    <= 1'b0;
      resp_eq    <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            state      <= CMP;
          end
        end
        CMP: begin
          resp_gt    <= cmp_gt;
          resp_lt    <= cmp_lt;
          resp_eq    <= cmp_eq;
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            done_count <= done_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_arbiter.sv
// Bench for comparator_arbiter: vector tables, directed multi-cycle sequences, and a
// randomized run against a transaction-level round-robin model.
module tb_comparator_arbiter;
  localparam int N  = 4;
  localparam int RW = 5;  // {id[1:0], gt, lt, eq}

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic           resp_gt;
  logic           resp_lt;
  logic           resp_eq;
  logic           busy;
  logic [7:0]     done_count;
  logic [1:0]     state_dbg;

  logic [N-1:0]   req_valid2;
  logic [4*N-1:0] req_a2;
  logic [4*N-1:0] req_b2;
  logic [N-1:0]   req_ready2;
  logic           resp_valid2;
  logic           resp_ready2;
  logic [1:0]     resp_id2;
  logic           resp_gt2;
  logic           resp_lt2;
  logic           resp_eq2;
  logic           busy2;
  logic [1:0]     done_count2;
  logic [1:0]     state_dbg2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  comparator_arbiter #(.NUM_REQ(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_gt(resp_gt), .resp_lt(resp_lt), .resp_eq(resp_eq),
    .busy(busy), .done_count(done_count), .state_dbg(state_dbg)
  );

  comparator_arbiter #(.NUM_REQ(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_a(req_a2), .req_b(req_b2),
    .req_ready(req_ready2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_id(resp_id2), .resp_gt(resp_gt2), .resp_lt(resp_lt2), .resp_eq(resp_eq2),
    .busy(busy2), .done_count(done_count2), .state_dbg(state_dbg2)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [RW-1:0] expect_resp(input int id, input logic [3:0] a,
                                                input logic [3:0] b);
    return {2'(id), (a > b), (a < b), (a == b)};
  endfunction

  // ---------------- vector tables ----------------
  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } pick_vec_t;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  id;
    logic [2:0]  cmp;  // {gt, lt, eq}
  } tx_vec_t;

  pick_vec_t pick_tbl[7];
  tx_vec_t   tx_tbl[6];

  logic [2:0] t2_cmp[4];
  logic [3:0] t4_exp[4];
  logic [1:0] t6_exp[4];

  int         pick;
  int         m_last;
  bit         m_out;
  int         m_age;
  int         m_count;
  int         ng;
  int         nr;
  int         last_cyc;
  logic [1:0] prev2;

  initial begin
    pick_tbl[0] = '{4'b0000, 4'b0000};
    pick_tbl[1] = '{4'b0001, 4'b0001};
    pick_tbl[2] = '{4'b1111, 4'b0001};
    pick_tbl[3] = '{4'b1000, 4'b1000};
    pick_tbl[4] = '{4'b0110, 4'b0010};
    pick_tbl[5] = '{4'b1100, 4'b0100};
    pick_tbl[6] = '{4'b1010, 4'b0010};

    tx_tbl[0] = '{4'b0001, 16'h0005, 16'h0003, 2'd0, 3'b100};
    tx_tbl[1] = '{4'b0110, 16'h0300, 16'h03F0, 2'd1, 3'b010};
    tx_tbl[2] = '{4'b0011, 16'h001F, 16'h002F, 2'd0, 3'b001};
    tx_tbl[3] = '{4'b1001, 16'hF001, 16'h0009, 2'd3, 3'b100};
    tx_tbl[4] = '{4'b1111, 16'h9990, 16'h1111, 2'd0, 3'b010};
    tx_tbl[5] = '{4'b0100, 16'h0800, 16'h0700, 2'd2, 3'b100};

    t2_cmp = '{3'b001, 3'b010, 3'b100, 3'b001};
    t4_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    t6_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

    req_valid  = '0; req_a  = '0; req_b  = '0; resp_ready  = 1'b0;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0; resp_ready2 = 1'b0;

    // Reset values, observed while reset is held.
    rst = 1'b1;
    #3;
    check("rst_ready", req_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", done_count, 0);
    check("rst_resp", {resp_id, resp_gt, resp_lt, resp_eq}, 0);
    apply_reset();

    // Arbitration pick from reset; valid is withdrawn before the edge so nothing is granted.
    for (int i = 0; i < 7; i++) begin
      req_valid = pick_tbl[i].valid;
      #1;
      check("pick_ready", req_ready, pick_tbl[i].exp_ready);
      req_valid = '0;
      step();
      check("pick_no_grant", busy, 0);
    end

    // One-shot transactions; operands are inverted after the handshake.
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = tx_tbl[i].valid;
      req_a     = tx_tbl[i].a;
      req_b     = tx_tbl[i].b;
      #1;
      check("tx_grant", req_ready, 32'd1 << tx_tbl[i].id);
      step();
      req_valid = '0;
      req_a     = ~req_a;
      req_b     = ~req_b;
      #1;
      check("tx_cmp_valid", resp_valid, 0);
      check("tx_cmp_busy", busy, 1);
      check("tx_cmp_ready", req_ready, 0);
      step();
      check("tx_resp_valid", resp_valid, 1);
      check("tx_resp", {resp_id, resp_gt, resp_lt, resp_eq}, {tx_tbl[i].id, tx_tbl[i].cmp});
      step();
      check("tx_count", done_count, i + 1);
      check("tx_idle", busy, 0);
    end

    // All four requesters valid at once, consumer always ready.
    apply_reset();
    req_a = 16'h4729;
    req_b = 16'h4189;
    req_valid = 4'hF;
    resp_ready = 1'b1;
    ng = 0; nr = 0; last_cyc = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      if (req_ready != 0 && ng < 4) begin
        check("t2_grant", req_ready, 32'd1 << ng);
        if (ng > 0) check("t2_gap", c - last_cyc, 3);
        last_cyc = c;
        ng++;
      end
      if (resp_valid && nr < 4) begin
        check("t2_resp", {resp_id, resp_gt, resp_lt, resp_eq}, {nr[1:0], t2_cmp[nr]});
        nr++;
      end
      step();
    end
    check("t2_done", nr, 4);
    req_valid = '0;

    // Back-pressure with another requester waiting.
    apply_reset();
    resp_ready = 1'b0;
    req_a = 16'h0003;
    req_b = 16'h0007;
    req_valid = 4'b0001;
    #1;
    check("t3_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_valid", resp_valid, 1);
      check("t3_resp", {resp_id, resp_gt, resp_lt, resp_eq}, {2'd0, 3'b010});
      check("t3_ready", req_ready, 0);
      check("t3_busy", busy, 1);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("t3_idle", busy, 0);
    check("t3_rv", resp_valid, 0);
    check("t3_next", req_ready, 4'b0010);
    check("t3_count", done_count, 1);
    req_valid = '0;

    // Two requesters held continuously must alternate.
    apply_reset();
    resp_ready = 1'b1;
    req_a = 16'h1234;
    req_b = 16'h4321;
    req_valid = 4'b1010;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready != 0) begin
        check("t4_grant", req_ready, t4_exp[ng]);
        ng++;
      end
      step();
    end
    check("t4_done", ng, 4);
    req_valid = '0;

    // Reset during CMP drops the in-flight result.
    apply_reset();
    req_a = 16'h0F00;
    req_b = 16'h0000;
    req_valid = 4'b0100;
    #1;
    check("t5_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    check("t5_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", resp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_resp", {resp_id, resp_gt, resp_lt, resp_eq}, 0);
    check("t5_rst_count", done_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5_quiet", resp_valid, 0);
      step();
    end
    req_valid = 4'b0101;
    #1;
    check("t5_next", req_ready, 4'b0001);
    req_valid = '0;
    step();

    // Narrow counter wraps.
    resp_ready2 = 1'b1;
    req_a2 = 16'h0006;
    req_b2 = 16'h0002;
    req_valid2 = 4'b0001;
    prev2 = done_count2;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      step();
      if (done_count2 != prev2) begin
        check("t6_count", done_count2, t6_exp[ng]);
        prev2 = done_count2;
        ng++;
      end
    end
    check("t6_done", ng, 4);
    req_valid2 = '0;

    // Randomized traffic against the transaction-level model.
    apply_reset();
    m_last = N - 1; m_out = 1'b0; m_age = 0; m_count = 0;
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_a      = 16'($urandom);
      req_b      = 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      pick = m_out ? -1 : rr_pick(req_valid, m_last);
      check("rnd_ready", req_ready, (pick >= 0) ? (32'd1 << pick) : 32'd0);
      check("rnd_valid", resp_valid, (m_out && m_age >= 2));
      check("rnd_busy", busy, m_out);
      check("rnd_count", done_count, m_count % 256);
      if (m_out && m_age >= 2) begin
        check("rnd_resp", {resp_id, resp_gt, resp_lt, resp_eq}, exp_q[0]);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          m_out = 1'b0;
          m_count++;
        end
      end else if (pick >= 0) begin
        exp_q.push_back(expect_resp(pick, req_a[4*pick +: 4], req_b[4*pick +: 4]));
        m_last = pick;
        m_out  = 1'b1;
        m_age  = 0;
      end
      if (m_out) m_age++;
      step();
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
